// File: rtl/fifo_fwft_if.sv
// Handshake bundle between the arbiter output, the FWFT FIFO and its consumer.
// DWIDTH and DEPTH must match the parameters of the fifo_fwft instance using it.
interface fifo_fwft_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DWIDTH-1:0] out_data;
    logic              out_ready;
    logic [CW-1:0]     count;
    logic              almost_full;

    // Environment side: drives the upstream stream and the consumer ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, almost_full
    );

    // FIFO side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, almost_full
    );
endinterface

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO behind the round-robin arbiter. Ready toward the
// arbiter depends only on registered state and flush, so the consumer's ready
// never propagates combinationally upstream.
module fifo_fwft #(
    parameter int unsigned DWIDTH          = 16,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned ALMOST_FULL_THR = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    fifo_fwft_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;

    // Handshake qualifiers; flush masks both sides so no transfer happens that cycle.
    always_comb begin
        in_ready  = (count_q != CW'(DEPTH)) & ~flush;
        out_valid = (count_q != '0) & ~flush;
        push      = bus.in_valid & in_ready;
        pop       = out_valid & bus.out_ready;
    end

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers; reset wins over flush, push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are hidden by out_valid gating.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    // Outputs presented to the interface.
    always_comb begin
        bus.in_ready    = in_ready;
        bus.out_valid   = out_valid;
        bus.out_data    = out_valid ? mem[rd_ptr_q] : '0;
        bus.count       = count_q;
        bus.almost_full = (count_q >= CW'(ALMOST_FULL_THR));
    end
endmodule

// File: tb/tb_fifo_fwft.sv
// Self-checking bench for fifo_fwft: a queue model checks every cycle, plus
// directed checks for the latency and boundary scenarios.
module tb_fifo_fwft;
    localparam int unsigned DWIDTH = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned THR    = 3;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    fifo_fwft_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) bus ();

    fifo_fwft #(
        .DWIDTH          (DWIDTH),
        .DEPTH           (DEPTH),
        .ALMOST_FULL_THR (THR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: entries pushed when the model accepts, popped and compared on output.
    logic [DWIDTH-1:0] sb_q[$];
    bit                sb_live = 1'b0;

    // Compare outputs mid-cycle against the model, then apply the coming edge.
    always @(negedge clk) begin
        bit               do_push;
        bit               do_pop;
        int               n;
        logic [DWIDTH-1:0] head;
        if (sb_live) begin
            n    = sb_q.size();
            head = (n != 0 && !flush) ? sb_q[0] : '0;
            check("sb_in_ready",  32'(bus.in_ready),    32'((n != DEPTH) && !flush));
            check("sb_out_valid", 32'(bus.out_valid),   32'((n != 0) && !flush));
            check("sb_out_data",  32'(bus.out_data),    32'(head));
            check("sb_count",     32'(bus.count),       32'(n));
            check("sb_almost",    32'(bus.almost_full), 32'(n >= THR));
        end
        if (reset) begin
            sb_q.delete();
            sb_live = 1'b1;
        end else if (sb_live) begin
            if (flush) begin
                sb_q.delete();
            end else begin
                do_pop  = (sb_q.size() != 0) && bus.out_ready;
                do_push = bus.in_valid && (sb_q.size() != DEPTH);
                if (do_pop) begin
                    check("sb_pop_data", 32'(bus.out_data), 32'(sb_q[0]));
                    void'(sb_q.pop_front());
                end
                if (do_push) begin
                    sb_q.push_back(bus.in_data);
                end
            end
        end
    end

    // Apply inputs for one cycle and return just after the active edge.
    task automatic drive(input logic v, input logic [DWIDTH-1:0] d, input logic r,
                         input logic f, input logic rst);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        flush         = f;
        reset         = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",     32'(bus.count),       32'd0);
        check("rst_in_ready",  32'(bus.in_ready),    32'd1);
        check("rst_out_valid", 32'(bus.out_valid),   32'd0);
        check("rst_out_data",  32'(bus.out_data),    32'd0);
        check("rst_almost",    32'(bus.almost_full), 32'd0);

        // Fill to full with the consumer stalled.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DWIDTH'(i), 1'b0, 1'b0, 1'b0);
            check("fill_count", 32'(bus.count), 32'(i));
            check("fill_head",  32'(bus.out_data), 32'h0001);
            check("fill_almost", 32'(bus.almost_full), 32'(i >= 3));
        end
        check("full_in_ready", 32'(bus.in_ready), 32'd0);

        // Full: pop proceeds, push of 0x0005 is refused.
        drive(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
        check("full_pop_count", 32'(bus.count),    32'd3);
        check("full_pop_ready", 32'(bus.in_ready), 32'd1);
        check("full_pop_head",  32'(bus.out_data), 32'h0002);

        // Drain to empty.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        check("drain_count", 32'(bus.count), 32'd0);

        // Streaming: count settles at 1 and pointers wrap repeatedly.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DWIDTH'(16'h0010 + i), 1'b1, 1'b0, 1'b0);
            check("stream_count", 32'(bus.count),    32'd1);
            check("stream_head",  32'(bus.out_data), 32'(16'h0010 + i));
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("stream_end_count", 32'(bus.count), 32'd0);

        // Flush with three entries buffered and both sides requesting.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, DWIDTH'(16'h0030 + i), 1'b0, 1'b0, 1'b0);
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0034;
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        #1;
        check("flush_in_ready_now",  32'(bus.in_ready),  32'd0);
        check("flush_out_valid_now", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("flush_count",     32'(bus.count),     32'd0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_out_data",  32'(bus.out_data),  32'd0);
        check("flush_in_ready",  32'(bus.in_ready),  32'd1);

        // Reset mid-operation discards entries and blocks the concurrent push.
        drive(1'b1, 16'h0041, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", 32'(bus.count), 32'd2);
        drive(1'b1, 16'h0043, 1'b0, 1'b0, 1'b1);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("midrst_count",     32'(bus.count),     32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_data",  32'(bus.out_data),  32'h00AA);
        check("post_rst_count", 32'(bus.count),     32'd1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Empty: out_ready is ignored; then a single push with no same-cycle bypass.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check("empty_count", 32'(bus.count), 32'd0);
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hBEEF;
        bus.out_ready = 1'b0;
        #1;
        check("no_bypass_valid", 32'(bus.out_valid), 32'd0);
        check("no_bypass_data",  32'(bus.out_data),  32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #1;
        check("beef_valid", 32'(bus.out_valid), 32'd1);
        check("beef_data",  32'(bus.out_data),  32'hBEEF);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("beef_drained", 32'(bus.count), 32'd0);

        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
